// File: rtl/can_rx_destuff_deser.sv
// CAN receive de-stuffer and deserialiser.
// Removes stuff bits from the sampled bit stream and flags stuff violations.
// Packs the data bits into DATA_W-bit words and queues them in a small FIFO
// that drains over a valid/ready port. The live shift register is also exported.
module can_rx_destuff_deser #(
  parameter int DATA_W        = 32,
  parameter int MSB_FIRST     = 1,
  parameter int STUFF_LEN     = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_PARTIAL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_active,
  input  logic                        sample_en,
  input  logic                        rx_bit,
  input  logic                        word_ready,
  output logic                        word_valid,
  output logic [DATA_W-1:0]           word_data,
  output logic [$clog2(DATA_W+1)-1:0] word_bits,
  output logic                        stuff_err,
  output logic                        overflow,
  output logic [DATA_W-1:0]           shift_out
);

  localparam int BCW = $clog2(DATA_W+1);
  localparam int RCW = $clog2(STUFF_LEN+1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BCW-1:0]    bits;
  } word_t;

  // De-stuff / deserialise state
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RCW-1:0]    run_cnt_q, run_cnt_d;
  logic              last_bit_q, last_bit_d;
  logic              stuff_pending_q, stuff_pending_d;
  logic              stuff_err_q, stuff_err_d;
  logic              fa_q, fa_d;

  // FIFO state
  word_t             mem_q [FIFO_DEPTH];
  word_t             mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              overflow_q, overflow_d;

  // Handshake between the deserialiser and the FIFO
  logic              push;
  word_t             push_word;
  logic              pop, full, wr_en;

  // Scratch values for a data bit
  logic [RCW-1:0]    run_nxt;
  logic [DATA_W-1:0] shreg_nxt;
  logic [BCW-1:0]    bit_nxt;

  // Bit acceptance: stuff-bit removal, run tracking, word assembly and partial flush
  always_comb begin
    shreg_d         = shreg_q;
    bit_cnt_d       = bit_cnt_q;
    run_cnt_d       = run_cnt_q;
    last_bit_d      = last_bit_q;
    stuff_pending_d = stuff_pending_q;
    stuff_err_d     = 1'b0;
    fa_d            = frame_active;
    push            = 1'b0;
    push_word       = '0;
    run_nxt         = '0;
    shreg_nxt       = '0;
    bit_nxt         = '0;

    if (!frame_active) begin
      // Idle between frames; a word still being assembled is flushed on the falling edge
      if (fa_q && (bit_cnt_q != '0) && (FLUSH_PARTIAL != 0)) begin
        push           = 1'b1;
        push_word.data = shreg_q;
        push_word.bits = bit_cnt_q;
      end
      shreg_d         = '0;
      bit_cnt_d       = '0;
      run_cnt_d       = '0;
      stuff_pending_d = 1'b0;
    end else if (sample_en) begin
      if (stuff_pending_q) begin
        // Stuff bit: must differ from the run it terminates; never shifted in
        stuff_err_d     = (rx_bit == last_bit_q);
        run_cnt_d       = RCW'(1);
        last_bit_d      = rx_bit;
        stuff_pending_d = 1'b0;
      end else begin
        run_nxt   = ((rx_bit == last_bit_q) && (run_cnt_q != '0)) ? run_cnt_q + RCW'(1) : RCW'(1);
        shreg_nxt = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], rx_bit}
                                     : {rx_bit, shreg_q[DATA_W-1:1]};
        bit_nxt   = bit_cnt_q + BCW'(1);
        run_cnt_d       = run_nxt;
        last_bit_d      = rx_bit;
        stuff_pending_d = (run_nxt == RCW'(STUFF_LEN));
        if (bit_nxt == BCW'(DATA_W)) begin
          // Full word: hand it off and restart; run state carries across words
          push           = 1'b1;
          push_word.data = shreg_nxt;
          push_word.bits = bit_nxt;
          shreg_d        = '0;
          bit_cnt_d      = '0;
        end else begin
          shreg_d   = shreg_nxt;
          bit_cnt_d = bit_nxt;
        end
      end
    end
  end

  // Deserialiser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q         <= '0;
      bit_cnt_q       <= '0;
      run_cnt_q       <= '0;
      last_bit_q      <= 1'b0;
      stuff_pending_q <= 1'b0;
      stuff_err_q     <= 1'b0;
      fa_q            <= 1'b0;
    end else begin
      shreg_q         <= shreg_d;
      bit_cnt_q       <= bit_cnt_d;
      run_cnt_q       <= run_cnt_d;
      last_bit_q      <= last_bit_d;
      stuff_pending_q <= stuff_pending_d;
      stuff_err_q     <= stuff_err_d;
      fa_q            <= fa_d;
    end
  end

  assign word_valid = (cnt_q != '0);
  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign pop        = word_valid & word_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign wr_en      = push & (~full | pop);

  // FIFO pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
    // A new frame starts with a clean overflow flag
    if (frame_active && !fa_q)  overflow_d = 1'b0;
    if (push && full && !pop)   overflow_d = 1'b1;
  end

  // FIFO storage write
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_word;
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are masked at the output whenever the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign word_data = word_valid ? mem_q[rd_ptr_q].data : '0;
  assign word_bits = word_valid ? mem_q[rd_ptr_q].bits : '0;
  assign stuff_err = stuff_err_q;
  assign overflow  = overflow_q;
  assign shift_out = shreg_q;

endmodule
